// File: rtl/wb_dma_fifo_periph.sv
// DMA target peripheral: producer words are buffered in a FIFO and drained over Wishbone DATA reads.
// dma_req_o is raised on a fill threshold or a queued packet end. Optional macro WB_DMA_PERIPH_RTY_EN: an empty DATA read returns RTY.
module wb_dma_fifo_periph #(
  parameter int FIFO_DEPTH = 16,
  parameter int DEF_THRESH = 4
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [3:2]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o,
  input  logic        prod_valid_i,
  input  logic [31:0] prod_data_i,
  input  logic        prod_last_i,
  output logic        prod_ready_o,
  output logic        dma_req_o,
  input  logic        dma_ack_i,
  output logic        dma_nd_o,
  output logic        dma_rest_o
);
  localparam int L = $clog2(FIFO_DEPTH);
  localparam logic [L:0] FULL_LEVEL = (L+1)'(FIFO_DEPTH);

  logic [31:0]           mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] tag_reg;
  logic [31:0]           mem_q_reg, reg_q_reg;
  logic [L-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [L:0]            level_reg, pending_reg, thresh_reg, thr_eff;
  logic en_reg, ovf_reg, req_reg, holdoff_reg, nd_reg, rest_reg;
  logic ack_reg, err_reg, rty_reg, data_sel_reg;
  logic empty, full, bus_req, rd, wr, is_data, is_status, is_ctrl, is_bad;
  logic pop, push, flush, empty_rd, pop_last, err_next, rty_next, ack_next;
  logic [31:0] status_word, ctrl_word;
  logic unused_bits;

  assign unused_bits = ^{wbs_sel_i, wbs_dat_i};

  assign empty     = (level_reg == '0);
  assign full      = (level_reg == FULL_LEVEL);
  assign bus_req   = wbs_cyc_i & wbs_stb_i & ~(ack_reg | err_reg | rty_reg);
  assign rd        = bus_req & ~wbs_we_i;
  assign wr        = bus_req & wbs_we_i;
  assign is_data   = (wbs_adr_i == 2'd0);
  assign is_status = (wbs_adr_i == 2'd1);
  assign is_ctrl   = (wbs_adr_i == 2'd2);
  assign is_bad    = (wbs_adr_i == 2'd3);
  assign empty_rd  = rd & is_data & empty;
  assign pop       = rd & is_data & ~empty;
  assign flush     = wr & is_ctrl & wbs_dat_i[31];
  // A word offered during a flush would land in a FIFO that is being emptied, so it is dropped.
  assign push      = prod_valid_i & ~full & ~flush;
  assign pop_last  = pop & tag_reg[rd_ptr_reg];
  assign thr_eff   = (thresh_reg == '0) ? (L+1)'(1) : thresh_reg;

`ifdef WB_DMA_PERIPH_RTY_EN
  assign rty_next = empty_rd;
  assign err_next = bus_req & ((is_data & wbs_we_i) | is_bad);
`else
  assign rty_next = 1'b0;
  assign err_next = bus_req & ((is_data & wbs_we_i) | is_bad | empty_rd);
`endif
  assign ack_next = bus_req & ~err_next & ~rty_next;

  always_comb begin
    status_word = '0;
    status_word[L:0] = level_reg;
    status_word[8] = empty;
    status_word[9] = full;
    status_word[16] = ovf_reg;
    ctrl_word = '0;
    ctrl_word[0] = en_reg;
    ctrl_word[L+8:8] = thresh_reg;
  end

  // Storage has no reset so it maps onto block RAM; read data is registered every cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= prod_data_i;
      tag_reg[wr_ptr_reg] <= prod_last_i;
    end
    mem_q_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ack_reg <= 1'b0; err_reg <= 1'b0; rty_reg <= 1'b0; data_sel_reg <= 1'b0;
      reg_q_reg <= '0;
      wr_ptr_reg <= '0; rd_ptr_reg <= '0; level_reg <= '0; pending_reg <= '0;
      en_reg <= 1'b0; thresh_reg <= (L+1)'(DEF_THRESH); ovf_reg <= 1'b0;
      req_reg <= 1'b0; holdoff_reg <= 1'b0; nd_reg <= 1'b0; rest_reg <= 1'b0;
    end else begin
      ack_reg <= ack_next;
      err_reg <= err_next;
      rty_reg <= rty_next;
      data_sel_reg <= is_data;
      reg_q_reg <= is_status ? status_word : ctrl_word;

      if (flush) begin
        wr_ptr_reg <= '0; rd_ptr_reg <= '0; level_reg <= '0; pending_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        level_reg   <= level_reg + (L+1)'(push) - (L+1)'(pop);
        pending_reg <= pending_reg + (L+1)'(push & prod_last_i) - (L+1)'(pop_last);
      end

      // A same-cycle overflow beats the W1C so an event is never lost.
      if (prod_valid_i & full)                    ovf_reg <= 1'b1;
      else if (wr & is_status & wbs_dat_i[16])    ovf_reg <= 1'b0;

      if (wr & is_ctrl) begin
        en_reg <= wbs_dat_i[0];
        thresh_reg <= wbs_dat_i[L+8:8];
      end

      rest_reg <= flush;
      nd_reg <= pop_last;
      holdoff_reg <= dma_ack_i & req_reg;

      if (flush | ~en_reg)            req_reg <= 1'b0;
      else if (dma_ack_i & req_reg)   req_reg <= 1'b0;
      else if (~holdoff_reg & ((level_reg >= thr_eff) | (pending_reg != '0)))
        req_reg <= 1'b1;
    end
  end

  assign wbs_dat_o    = ack_reg ? (data_sel_reg ? mem_q_reg : reg_q_reg) : '0;
  assign wbs_ack_o    = ack_reg;
  assign wbs_err_o    = err_reg;
  assign wbs_rty_o    = rty_reg;
  assign prod_ready_o = ~full;
  assign dma_req_o    = req_reg;
  assign dma_nd_o     = nd_reg;
  assign dma_rest_o   = rest_reg;
endmodule

// File: tb/tb_wb_dma_fifo_periph.sv
// Directed bench for wb_dma_fifo_periph: reset, threshold request, packet-end request, overflow, flush, bus errors.
module tb_wb_dma_fifo_periph;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [3:2]  wbs_adr_i;
  logic [31:0] wbs_dat_i, wbs_dat_o;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o, wbs_rty_o;
  logic        prod_valid_i, prod_last_i, prod_ready_o;
  logic [31:0] prod_data_i;
  logic        dma_req_o, dma_ack_i, dma_nd_o, dma_rest_o;

  int n_checks = 0;
  int n_fail = 0;
  logic snap_nd, snap_rest, snap_req;

  wb_dma_fifo_periph #(.FIFO_DEPTH(16), .DEF_THRESH(4)) dut (
    .clk(clk), .rst_i(rst_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o), .wbs_sel_i(wbs_sel_i),
    .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
    .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
    .prod_valid_i(prod_valid_i), .prod_data_i(prod_data_i), .prod_last_i(prod_last_i),
    .prod_ready_o(prod_ready_o),
    .dma_req_o(dma_req_o), .dma_ack_i(dma_ack_i), .dma_nd_o(dma_nd_o), .dma_rest_o(dma_rest_o)
  );

  always #5 clk = ~clk;

  // Called and returns one time unit after a rising edge; takes two cycles.
  task automatic wb_access(input logic [1:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] q, output logic ack, output logic err, output logic rty);
    wbs_adr_i = a; wbs_we_i = we; wbs_dat_i = d; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    @(posedge clk); #1;
    q = wbs_dat_o; ack = wbs_ack_o; err = wbs_err_o; rty = wbs_rty_o;
    snap_nd = dma_nd_o; snap_rest = dma_rest_o; snap_req = dma_req_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    $display("wb adr=%0d we=%0b wdata=%h rdata=%h ack=%0b err=%0b rty=%0b", a, we, d, q, ack, err, rty);
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic last);
    prod_valid_i = 1'b1; prod_data_i = d; prod_last_i = last;
    @(posedge clk); #1;
    prod_valid_i = 1'b0; prod_last_i = 1'b0;
    $display("push data=%h last=%0b", d, last);
  endtask

  task automatic ack_pulse();
    dma_ack_i = 1'b1;
    @(posedge clk); #1;
    dma_ack_i = 1'b0;
    $display("dma_ack pulse");
  endtask

  task automatic test_reset();
    logic [31:0] q; logic a, e, r;
    n_checks++;
    if ({wbs_ack_o, wbs_err_o, wbs_rty_o, dma_req_o, dma_nd_o, dma_rest_o, prod_ready_o} !== 7'b0000001) begin
      n_fail++; $display("FAIL reset_outputs: got %b expected 0000001",
        {wbs_ack_o, wbs_err_o, wbs_rty_o, dma_req_o, dma_nd_o, dma_rest_o, prod_ready_o});
    end
    n_checks++;
    if (wbs_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h expected 00000000", wbs_dat_o); end
    wb_access(2'd2, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0400 || a !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl: got %h ack %b expected 00000400 ack 1", q, a); end
    // reset while a response is pending
    push_word(32'hAA, 1'b0);
    wbs_adr_i = 2'd1; wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    #2 rst_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (wbs_ack_o !== 1'b0 || prod_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_midcycle: got ack %b ready %b expected ack 0 ready 1", wbs_ack_o, prod_ready_o);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(posedge clk); #1;
    wb_access(2'd1, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0100) begin n_fail++; $display("FAIL reset_status: got %h expected 00000100", q); end
  endtask

  task automatic test_threshold();
    logic [31:0] q; logic a, e, r;
    wb_access(2'd2, 1'b1, 32'h0000_0401, q, a, e, r);
    for (int i = 0; i < 4; i++) push_word(32'h11 + i, 1'b0);
    n_checks++;
    if (dma_req_o !== 1'b0) begin n_fail++; $display("FAIL thr_req_early: got %b expected 0", dma_req_o); end
    @(posedge clk); #1;
    n_checks++;
    if (dma_req_o !== 1'b1) begin n_fail++; $display("FAIL thr_req_set: got %b expected 1", dma_req_o); end
    for (int i = 0; i < 4; i++) begin
      wb_access(2'd0, 1'b0, 32'h0, q, a, e, r);
      n_checks++;
      if (q !== 32'h11 + i || a !== 1'b1) begin
        n_fail++; $display("FAIL thr_read%0d: got %h ack %b expected %h ack 1", i, q, a, 32'h11 + i);
      end
    end
    n_checks++;
    if (dma_req_o !== 1'b1) begin n_fail++; $display("FAIL thr_req_held: got %b expected 1", dma_req_o); end
    ack_pulse();
    n_checks++;
    if (dma_req_o !== 1'b0) begin n_fail++; $display("FAIL thr_req_clear: got %b expected 0", dma_req_o); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dma_req_o !== 1'b0) begin n_fail++; $display("FAIL thr_req_stays: got %b expected 0", dma_req_o); end
  endtask

  task automatic test_packet_last();
    logic [31:0] q; logic a, e, r;
    push_word(32'h21, 1'b0);
    push_word(32'h22, 1'b1);
    n_checks++;
    if (dma_req_o !== 1'b0) begin n_fail++; $display("FAIL pkt_req_early: got %b expected 0", dma_req_o); end
    @(posedge clk); #1;
    n_checks++;
    if (dma_req_o !== 1'b1) begin n_fail++; $display("FAIL pkt_req_set: got %b expected 1", dma_req_o); end
    wb_access(2'd0, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h21 || snap_nd !== 1'b0) begin n_fail++; $display("FAIL pkt_pop1: got %h nd %b expected 00000021 nd 0", q, snap_nd); end
    wb_access(2'd0, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h22 || snap_nd !== 1'b1) begin n_fail++; $display("FAIL pkt_pop2: got %h nd %b expected 00000022 nd 1", q, snap_nd); end
    n_checks++;
    if (dma_nd_o !== 1'b0) begin n_fail++; $display("FAIL pkt_nd_width: got %b expected 0", dma_nd_o); end
    ack_pulse();
    n_checks++;
    if (dma_req_o !== 1'b0) begin n_fail++; $display("FAIL pkt_req_clear: got %b expected 0", dma_req_o); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dma_req_o !== 1'b0) begin n_fail++; $display("FAIL pkt_req_stays: got %b expected 0", dma_req_o); end
  endtask

  task automatic test_overflow();
    logic [31:0] q; logic a, e, r;
    wb_access(2'd2, 1'b1, 32'h0000_0400, q, a, e, r);
    for (int i = 0; i < 16; i++) push_word(32'h100 + i, 1'b0);
    n_checks++;
    if (prod_ready_o !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b expected 0", prod_ready_o); end
    push_word(32'hDEAD, 1'b0);
    wb_access(2'd1, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0001_0210) begin n_fail++; $display("FAIL ovf_status: got %h expected 00010210", q); end
    wb_access(2'd1, 1'b1, 32'h0001_0000, q, a, e, r);
    wb_access(2'd1, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0210) begin n_fail++; $display("FAIL ovf_w1c: got %h expected 00000210", q); end
    for (int i = 0; i < 16; i++) begin
      wb_access(2'd0, 1'b0, 32'h0, q, a, e, r);
      n_checks++;
      if (q !== 32'h100 + i) begin n_fail++; $display("FAIL ovf_drain%0d: got %h expected %h", i, q, 32'h100 + i); end
    end
    wb_access(2'd1, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0100) begin n_fail++; $display("FAIL ovf_empty: got %h expected 00000100", q); end
  endtask

  task automatic test_flush();
    logic [31:0] q; logic a, e, r;
    wb_access(2'd2, 1'b1, 32'h0000_0401, q, a, e, r);
    for (int i = 0; i < 6; i++) push_word(32'h31 + i, 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (dma_req_o !== 1'b1) begin n_fail++; $display("FAIL flush_req_before: got %b expected 1", dma_req_o); end
    wb_access(2'd1, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0006) begin n_fail++; $display("FAIL flush_level6: got %h expected 00000006", q); end
    wb_access(2'd2, 1'b1, 32'h8000_0401, q, a, e, r);
    n_checks++;
    if (snap_rest !== 1'b1 || snap_req !== 1'b0) begin
      n_fail++; $display("FAIL flush_pulse: got rest %b req %b expected rest 1 req 0", snap_rest, snap_req);
    end
    n_checks++;
    if (dma_rest_o !== 1'b0 || dma_req_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_after: got rest %b req %b expected 0 0", dma_rest_o, dma_req_o);
    end
    wb_access(2'd1, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0100) begin n_fail++; $display("FAIL flush_status: got %h expected 00000100", q); end
    wb_access(2'd2, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0401) begin n_fail++; $display("FAIL flush_ctrl: got %h expected 00000401", q); end
  endtask

  task automatic test_bus_errors();
    logic [31:0] q; logic a, e, r;
    wb_access(2'd0, 1'b0, 32'h0, q, a, e, r);
`ifdef WB_DMA_PERIPH_RTY_EN
    n_checks++;
    if ({a, e, r} !== 3'b001) begin n_fail++; $display("FAIL empty_read: got ack/err/rty %b expected 001", {a, e, r}); end
`else
    n_checks++;
    if ({a, e, r} !== 3'b010) begin n_fail++; $display("FAIL empty_read: got ack/err/rty %b expected 010", {a, e, r}); end
`endif
    n_checks++;
    if (wbs_err_o !== 1'b0 || wbs_rty_o !== 1'b0) begin
      n_fail++; $display("FAIL resp_width: got err %b rty %b expected 0 0", wbs_err_o, wbs_rty_o);
    end
    wb_access(2'd1, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if (q !== 32'h0000_0100) begin n_fail++; $display("FAIL err_level: got %h expected 00000100", q); end
    wb_access(2'd0, 1'b1, 32'h1234, q, a, e, r);
    n_checks++;
    if ({a, e, r} !== 3'b010) begin n_fail++; $display("FAIL data_write: got ack/err/rty %b expected 010", {a, e, r}); end
    wb_access(2'd3, 1'b0, 32'h0, q, a, e, r);
    n_checks++;
    if ({a, e, r} !== 3'b010 || q !== 32'h0) begin
      n_fail++; $display("FAIL adr3: got ack/err/rty %b data %h expected 010 data 0", {a, e, r}, q);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    wbs_adr_i = 2'd0; wbs_dat_i = '0; wbs_sel_i = 4'hF; wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    prod_valid_i = 1'b0; prod_data_i = '0; prod_last_i = 1'b0; dma_ack_i = 1'b0;
    snap_nd = 1'b0; snap_rest = 1'b0; snap_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    test_reset();
    test_threshold();
    test_packet_last();
    test_overflow();
    test_flush();
    test_bus_errors();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
